// File: rtl/tpu_act_pkg.sv
// tpu_act_pkg: shared activation mode encodings, tile FSM states and element indexing.
package tpu_act_pkg;
  localparam logic [1:0] ACT_PASS   = 2'b00;
  localparam logic [1:0] ACT_RELU_T = 2'b01;
  localparam logic [1:0] ACT_CLAMP  = 2'b10;
  localparam logic [1:0] ACT_LEAKY  = 2'b11;
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;
  function automatic int idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/activ_lane.sv
// activ_lane: combinational per-element activation selected by mode against thresh.
module activ_lane
  import tpu_act_pkg::*;
#(
  parameter int DW     = 8,
  parameter int LSHIFT = 2
) (
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_thresh,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_y
);
  logic w_gt;
  assign w_gt = i_x > i_thresh;
  assign o_y = (i_mode == ACT_RELU_T) ? (w_gt ? i_x : '0) :
               (i_mode == ACT_CLAMP)  ? (w_gt ? i_thresh : i_x) :
               (i_mode == ACT_LEAKY)  ? (w_gt ? i_x : i_x >> LSHIFT) : i_x;
endmodule

// File: rtl/activ_tile.sv
// activ_tile: collects per-lane activated elements into an N x N tile, presented via valid/ready.
module activ_tile
  import tpu_act_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int LSHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DW-1:0]     thresh,
  input  logic [N*DW-1:0]   acin,
  input  logic [N-1:0]      dv_acin,
  output logic              in_ready,
  output logic [N*N*DW-1:0] acout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_ovf
);
  localparam int CW = $clog2(N + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt [N];
  logic [N*N*DW-1:0] r_tile;
  logic r_err;
  logic [N*DW-1:0] w_y;
  logic [N-1:0] w_acc, w_drop, w_done;
  logic w_fire;
  genvar l;
  generate
    for (l = 0; l < N; l++) begin : g_lane
      activ_lane #(.DW(DW), .LSHIFT(LSHIFT)) u_lane (
        .i_mode(mode), .i_thresh(thresh), .i_x(acin[l*DW +: DW]), .o_y(w_y[l*DW +: DW])
      );
      assign w_acc[l]  = in_ready & dv_acin[l] & (r_cnt[l] != CW'(N));
      assign w_drop[l] = in_ready & dv_acin[l] & (r_cnt[l] == CW'(N));
      // a lane counts as done if already full or filling its last column on this edge
      assign w_done[l] = (r_cnt[l] == CW'(N)) | (w_acc[l] & (r_cnt[l] == CW'(N - 1)));
    end
  endgenerate
  assign in_ready  = r_state == COLLECT;
  assign out_valid = r_state == HOLD;
  assign w_fire    = out_valid & out_ready;
  assign acout     = r_tile;
  assign err_ovf   = r_err;
  always_comb begin
    w_next = r_state;
    if (r_state == COLLECT && &w_done) w_next = HOLD;
    if (w_fire) w_next = COLLECT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_tile  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      for (int i = 0; i < N; i++) begin
        if (w_acc[i]) begin
          r_tile[idx(i, int'(r_cnt[i]), N)*DW +: DW] <= w_y[i*DW +: DW];
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        if (w_fire) r_cnt[i] <= '0;
      end
      if (|w_drop) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_activ_tile.sv
// tb_activ_tile: randomized + directed scoreboard bench for activ_tile against a tile-level model.
module tb_activ_tile;
  localparam int N = 4, DW = 8, LSHIFT = 2, TW = N * N * DW;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [1:0] mode = '0;
  logic [DW-1:0] thresh = '0;
  logic [N*DW-1:0] acin = '0;
  logic [N-1:0] dv_acin = '0;
  logic in_ready, out_valid, err_ovf;
  logic [TW-1:0] acout;
  int checks = 0, failures = 0;
  int mcnt [N];
  logic [DW-1:0] mt [N][N];
  bit mhold = 1'b0, merr = 1'b0;
  logic [TW-1:0] q [$];

  activ_tile #(.N(N), .DW(DW), .LSHIFT(LSHIFT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .thresh(thresh), .acin(acin), .dv_acin(dv_acin),
    .in_ready(in_ready), .acout(acout), .out_valid(out_valid), .out_ready(out_ready),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] act_f(input logic [1:0] md, input logic [DW-1:0] x,
                                          input logic [DW-1:0] th);
    int xi, ti;
    xi = int'(x);
    ti = int'(th);
    case (md)
      2'd1: return (xi > ti) ? x : DW'(0);
      2'd2: return (xi > ti) ? th : x;
      2'd3: return (xi > ti) ? x : DW'(xi / (1 << LSHIFT));
      default: return x;
    endcase
  endfunction

  function automatic logic [TW-1:0] pack_tile();
    logic [TW-1:0] t;
    t = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) t[(r*N+c)*DW +: DW] = mt[r][c];
    return t;
  endfunction

  task automatic model_reset();
    mhold = 1'b0;
    merr = 1'b0;
    q.delete();
    for (int r = 0; r < N; r++) begin
      mcnt[r] = 0;
      for (int c = 0; c < N; c++) mt[r][c] = '0;
    end
  endtask

  task automatic cyc(input logic [N-1:0] m, input logic [N*DW-1:0] v, input logic [1:0] md,
                     input logic [DW-1:0] th, input logic ordy);
    bit full;
    @(negedge clk);
    dv_acin = m; acin = v; mode = md; thresh = th; out_ready = ordy;
    @(posedge clk);
    if (mhold) begin
      if (ordy) begin
        mhold = 1'b0;
        for (int r = 0; r < N; r++) mcnt[r] = 0;
      end
    end else begin
      full = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (m[r]) begin
          if (mcnt[r] < N) begin
            mt[r][mcnt[r]] = act_f(md, v[r*DW +: DW], th);
            mcnt[r]++;
          end else merr = 1'b1;
        end
        if (mcnt[r] != N) full = 1'b0;
      end
      if (full) begin
        mhold = 1'b1;
        q.push_back(pack_tile());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dv_acin = '0; out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", TW'(out_valid), TW'(0));
    check("rst_in_ready", TW'(in_ready), TW'(1));
    check("rst_acout", acout, '0);
    check("rst_err_ovf", TW'(err_ovf), TW'(0));
  endtask

  // monitor: compare handshake/flag state every cycle, pop a tile when out_valid rises
  initial begin
    logic prev_ov;
    logic [TW-1:0] cur;
    prev_ov = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", TW'(out_valid), TW'(mhold));
        check("in_ready", TW'(in_ready), TW'(!mhold));
        check("err_ovf", TW'(err_ovf), TW'(merr));
        if (out_valid) begin
          if (!prev_ov) begin
            if (q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_tile: got %h expected none", acout);
            end else cur = q.pop_front();
          end
          check("tile", acout, cur);
        end
        prev_ov = out_valid;
      end else prev_ov = 1'b0;
    end
  end

  localparam logic [N-1:0] SKEW [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  initial begin
    logic [N*DW-1:0] v;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    // T1: RELU_T skew
    for (int i = 0; i < 7; i++) cyc(SKEW[i], {8'd200, 8'd11, 8'd10, 8'd5}, 2'd1, 8'd10, 1'b0);
    // T2: stall in hold with changing inputs, then fire
    for (int i = 0; i < 5; i++) cyc(N'($urandom), $urandom, 2'($urandom), DW'($urandom), 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    // T3: CLAMP full-width
    for (int i = 0; i < 4; i++) cyc(4'b1111, {8'd150, 8'd50, 8'd150, 8'd50}, 2'd2, 8'd100, 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    // T4: LEAKY then PASS
    for (int i = 0; i < 4; i++) cyc(4'b1111, {8'd3, 8'd11, 8'd0, 8'd9}, 2'd3, 8'd10, 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b1111, {4{8'd3}}, 2'd0, 8'd10, 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    // T5: lane0 overflow while lane3 at col 1
    cyc(4'b1001, $urandom, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, $urandom, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b1110, $urandom, 2'd0, 8'd0, 1'b0);
    cyc(4'b0110, $urandom, 2'd0, 8'd0, 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b1111, $urandom, 2'd1, 8'd60, 1'b0);
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    // T6: reset mid-tile, then fresh skew tile
    for (int i = 0; i < 3; i++) cyc(SKEW[i], $urandom, 2'd0, 8'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      v = $urandom;
      cyc(SKEW[i], v, 2'd3, 8'd40, 1'b0);
    end
    cyc('0, '0, 2'd0, 8'd0, 1'b1);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(N'($urandom), $urandom, 2'($urandom), DW'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) cyc('0, '0, 2'd0, 8'd0, 1'b1);
    @(negedge clk);
    check("queue_drained", TW'(q.size()), TW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
